// File: rtl/enhanced_ctrl.sv
// enhanced_ctrl: control-unit FSM for the enhanced 8-instruction accumulator
// processor. It sequences START -> FETCH -> DECODE -> one execute state per
// opcode, and decodes the datapath control lines from the current state.
// Optional build macro: ENHANCED_ENTER_WAIT_EN -- when defined, INPUT waits
// for the enter strobe; when undefined, INPUT lasts a single cycle.
module enhanced_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
    input  logic [2:0] ir,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [3:0] showstate
);

    typedef enum logic [3:0] {
        START  = 4'b0000,
        FETCH  = 4'b0001,
        DECODE = 4'b0010,
        LOAD   = 4'b1000,
        STORE  = 4'b1001,
        ADD    = 4'b1010,
        SUB    = 4'b1011,
        INPUT  = 4'b1100,
        JZ     = 4'b1101,
        JPOS   = 4'b1110,
        HALT   = 4'b1111
    } state_t;

    state_t state;
    state_t next_state;

    // State register; active-low reset aborts any instruction back to START.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= START;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; execute states are entered at {1, opcode}.
    always_comb begin
        next_state = START;
        case (state)
            START:  next_state = FETCH;
            FETCH:  next_state = DECODE;
            DECODE: next_state = state_t'({1'b1, ir});
            LOAD:   next_state = START;
            STORE:  next_state = START;
            ADD:    next_state = START;
            SUB:    next_state = START;
`ifdef ENHANCED_ENTER_WAIT_EN
            INPUT:  next_state = enter ? START : INPUT;
`else
            INPUT:  next_state = START;
`endif
            JZ:     next_state = START;
            JPOS:   next_state = START;
            HALT:   next_state = HALT;
            default: next_state = START;
        endcase
    end

    // Control-line decode of the current state; jumps also use the A flags.
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = 2'b00;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        case (state)
            FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            DECODE: begin
                Meminst = 1'b1;
            end
            LOAD: begin
                Asel  = 2'b10;
                Aload = 1'b1;
            end
            STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            ADD: begin
                Asel  = 2'b00;
                Aload = 1'b1;
            end
            SUB: begin
                Aload = 1'b1;
                Sub   = 1'b1;
            end
            INPUT: begin
                Asel  = 2'b01;
                Aload = 1'b1;
            end
            JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            HALT: begin
                Halt = 1'b1;
            end
            default: begin
                IRload = 1'b0;
            end
        endcase
    end

    assign showstate = state;

endmodule

// File: tb/tb_enhanced_ctrl.sv
// tb_enhanced_ctrl: randomized self-checking bench for enhanced_ctrl against
// an instruction-level reference model (state code + output table).
module tb_enhanced_ctrl;

    logic       clock;
    logic       reset;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic [2:0] ir;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic [1:0] Asel;
    logic       Aload;
    logic       Sub;
    logic       Halt;
    logic [3:0] showstate;

    int unsigned n_checks;
    int unsigned n_fails;

    enhanced_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .Aeq0     (Aeq0),
        .Apos     (Apos),
        .enter    (enter),
        .ir       (ir),
        .IRload   (IRload),
        .JMPmux   (JMPmux),
        .PCload   (PCload),
        .Meminst  (Meminst),
        .MemWr    (MemWr),
        .Asel     (Asel),
        .Aload    (Aload),
        .Sub      (Sub),
        .Halt     (Halt),
        .showstate(showstate)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,Halt}
    function automatic logic [9:0] model_outputs(input int code, input logic z, input logic p);
        case (code)
            1:  return 10'b1010000000;
            2:  return 10'b0001000000;
            8:  return 10'b0000010100;
            9:  return 10'b0001100000;
            10: return 10'b0000000100;
            11: return 10'b0000000110;
            12: return 10'b0000001100;
            13: return {2'b01, z, 7'b0000000};
            14: return {2'b01, p, 7'b0000000};
            15: return 10'b0000000001;
            default: return 10'b0000000000;
        endcase
    endfunction

    // Instruction-level sequencing: fetch, decode, execute opcode, repeat.
    function automatic int model_next(input int code, input logic [2:0] op, input logic ent);
        if (code == 0) return 1;
        if (code == 1) return 2;
        if (code == 2) return 8 + int'(op);
        if (code == 15) return 15;
`ifdef ENHANCED_ENTER_WAIT_EN
        if (code == 12) return ent ? 0 : 12;
`endif
        return 0;
    endfunction

    function automatic logic [9:0] dut_vec();
        return {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, Halt};
    endfunction

    int          model;
    int          nxt;
    int unsigned halt_cnt;
    int unsigned halt_limit;
    bit          long_halt_done;
    bit          do_reset;
    int          visits [16];

    initial begin
        n_checks = 0;
        n_fails = 0;
        reset = 1'b0;
        Aeq0 = 1'b0;
        Apos = 1'b0;
        enter = 1'b0;
        ir = 3'b000;
        model = 0;
        halt_cnt = 0;
        halt_limit = 120;
        long_halt_done = 1'b0;
        foreach (visits[k]) visits[k] = 0;

        @(negedge clock);
        check_eq("reset_state", {12'd0, showstate}, 16'd0);
        check_eq("reset_outputs", {6'd0, dut_vec()}, 16'd0);
        reset = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            ir    = 3'($urandom_range(0, 7));
            Aeq0  = 1'($urandom_range(0, 1));
            Apos  = 1'($urandom_range(0, 1));
            enter = ($urandom_range(0, 3) == 0);
            #1;
            check_eq("state", {12'd0, showstate}, 16'(model));
            check_eq("outputs", {6'd0, dut_vec()}, {6'd0, model_outputs(model, Aeq0, Apos)});
            visits[model]++;

            if (model == 15) halt_cnt++;
            else halt_cnt = 0;

            do_reset = 1'b0;
            if (reset == 1'b0) begin
                reset = 1'b1;
            end else if (model == 15 && halt_cnt >= halt_limit) begin
                do_reset = 1'b1;
                long_halt_done = 1'b1;
                halt_limit = $urandom_range(1, 6);
            end else if ($urandom_range(0, 99) == 0) begin
                do_reset = 1'b1;
            end

            if (do_reset) begin
                #1;
                reset = 1'b0;
                #1;
                check_eq("async_reset_state", {12'd0, showstate}, 16'd0);
                check_eq("async_reset_outputs", {6'd0, dut_vec()}, 16'd0);
                model = 0;
                halt_cnt = 0;
            end

            nxt = (reset == 1'b0) ? 0 : model_next(model, ir, enter);
            @(posedge clock);
            model = nxt;
            @(negedge clock);
        end

        check_eq("long_halt_seen", {15'd0, long_halt_done}, 16'd1);
        for (int s = 8; s < 16; s++) begin
            check_eq("exec_state_visited", {15'd0, visits[s] > 0}, 16'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/enhanced_ctrl.md
Name: enhanced_ctrl

Overview:
- Control-unit FSM for the enhanced 8-instruction accumulator processor.
- Sequences start, fetch, decode and one execute state per opcode.
- Drives the datapath control lines: IR/PC load, jump mux, memory access, A-register select/load, subtract, halt.
- Exposes the current state code for debug/display.

Parameters:
- None. State encodings are fixed constants listed under Behaviour.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces state to START immediately.
- Aeq0  in  1  datapath flag: accumulator A == 0.
- Apos  in  1  datapath flag: accumulator A > 0.
- enter  in  1  user input-ready strobe (used only in INPUT state).
- ir  in  3  opcode field of instruction register.
- IRload  out  1  load instruction register.
- JMPmux  out  1  select IR address field as PC source.
- PCload  out  1  load program counter.
- Meminst  out  1  memory address from IR address field.
- MemWr  out  1  memory write enable.
- Asel  out  2  A-input select: 00 = adder/subtractor, 01 = external input, 10 = memory, 11 = unused.
- Aload  out  1  load accumulator A.
- Sub  out  1  0 = add, 1 = subtract.
- Halt  out  1  processor halted.
- showstate  out  4  current state code.

Behaviour:
- Single 4-bit state register.
- Reset: reset=0 asynchronously sets state to START (0000), so all control outputs are 0 and showstate=0000 while reset is held.
- All outputs are combinational decode of the current state. PCload in JZ/JPOS also depends on the flags.
- Output vector {IRload,JMPmux,PCload,Meminst,MemWr,Asel,Aload,Sub,Halt} per state:
  - START 0000: 0000000000; next state FETCH.
  - FETCH 0001: 1010000000 (IRload, PCload); next state DECODE.
  - DECODE 0010: 0001000000 (Meminst); next state = {1'b1, ir}.
  - LOAD 1000 (ir=000): 0000010100 (Asel=10, Aload); next state START.
  - STORE 1001 (ir=001): 0001100000 (Meminst, MemWr); next state START.
  - ADD 1010 (ir=010): 0000000100 (Asel=00, Aload); next state START.
  - SUB 1011 (ir=011): 0000000110 (Aload, Sub); next state START.
  - INPUT 1100 (ir=100): 0000001100 (Asel=01, Aload); next state per Optional Feature.
  - JZ 1101 (ir=101): JMPmux=1, PCload=Aeq0, all other outputs 0; next state START.
  - JPOS 1110 (ir=110): JMPmux=1, PCload=Apos, all other outputs 0; next state START.
  - HALT 1111 (ir=111): 0000000001; stays in HALT until reset.
- ir, Aeq0 and Apos are sampled only where listed above. Changes to them in other states have no effect.
- Unused codes (0011–0111) output all zeros and go to START on the next clock.
- Reset asserted mid-instruction aborts the instruction: state goes to START asynchronously. After reset deasserts, the first rising edge moves START to FETCH.
- showstate always equals the state register value.

Optional Feature:
- Macro ENHANCED_ENTER_WAIT_EN.
- Defined: INPUT holds, keeping Aload=1 and Asel=01 each cycle, while enter=0. When enter=1 at the rising edge, next state is START.
- Undefined: enter is ignored; INPUT lasts one cycle, then START.

Test Plan:
- Reset low, then high at the first negedge: showstate=0000, all outputs 0. Next edges give the sequence 0000→0001 (outputs 1010000000)→0010 (0001000000).
- ir=000: DECODE→1000, outputs 0000010100, then 0000. Repeat with ir=001/010/011: 1001/1010/1011 with outputs 0001100000/0000000100/0000000110.
- ir=100, enter=0 then enter=1:
  - With ENHANCED_ENTER_WAIT_EN: stays at 1100 (0000001100) until enter=1, then 0000.
  - Without the macro: 1100 for one cycle, then 0000.
- ir=101: with Aeq0=1 outputs 0110000000; with Aeq0=0 outputs 0100000000. ir=110 with Apos=1/0 gives the same pair at state 1110.
- ir=111: reaches 1111, outputs 0000000001, holds for 100+ cycles regardless of ir/enter changes. Asserting reset returns to 0000 immediately, without waiting for a clock edge.
- Change ir in FETCH and in an execute state: the state sequence is unaffected. Only the ir value present at the DECODE edge selects the execute state.
